// File: rtl/gba_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gba_timer_bank                                             |
// | Description : Bank of NUM_TIMERS GBA-style up-counters. The bank shares  |
// |               one free-running prescaler. Each timer has a reload        |
// |               register and a control register. A timer can be chained    |
// |               to the one below it (count-up cascade), and each timer     |
// |               raises an overflow interrupt.                              |
// | Ports       : internal_clock/reset - clock, async active-high reset      |
// |               wr_en/wr_idx/wr_ctrl/wr_data - register write port         |
// |                 (wr_ctrl=1 control register, 0 reload register)          |
// |               irq_ack   - per-timer acknowledge (latched-IRQ build only) |
// |               count_out - live counters, timer n at [n*WIDTH +: WIDTH]   |
// |               overflow  - 1-cycle wrap pulse per timer                   |
// |               irq       - interrupt request per timer                    |
// | Options     : define TIMER_IRQ_LATCH_EN for sticky, acknowledged IRQs;   |
// |               otherwise irq is the combinational overflow & irq_en pulse |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gba_timer_bank #(
  parameter int NUM_TIMERS    = 4,
  parameter int WIDTH         = 16,
  parameter int PRESCALE_BITS = 10,
  localparam int IDX_W        = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                        internal_clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic                        wr_ctrl,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NUM_TIMERS-1:0]       irq_ack,
  output logic [NUM_TIMERS*WIDTH-1:0] count_out,
  output logic [NUM_TIMERS-1:0]       overflow,
  output logic [NUM_TIMERS-1:0]       irq
);

  // The /1024 tap reads pre_q[9:0], so PRESCALE_BITS must be at least 10.
  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic [WIDTH-1:0]         cnt_q    [NUM_TIMERS];
  logic [WIDTH-1:0]         cnt_d    [NUM_TIMERS];
  logic [WIDTH-1:0]         reload_q [NUM_TIMERS];
  logic [WIDTH-1:0]         reload_d [NUM_TIMERS];
  logic [1:0]               presc_q  [NUM_TIMERS];
  logic [1:0]               presc_d  [NUM_TIMERS];
  logic [NUM_TIMERS-1:0]    cup_q, cup_d;
  logic [NUM_TIMERS-1:0]    irqen_q, irqen_d;
  logic [NUM_TIMERS-1:0]    en_q, en_d;
  logic [NUM_TIMERS-1:0]    irq_pulse;

  logic tick_64, tick_256, tick_1024;
  assign tick_64   = &pre_q[5:0];
  assign tick_256  = &pre_q[7:0];
  assign tick_1024 = &pre_q[9:0];

  always_comb begin : c_next
    logic carry;     // overflow of the timer below, for cascade ripple
    logic sel_tick;
    logic inc;
    logic ctrl_wr;
    logic rel_wr;
    logic stopping;
    logic starting;
    logic wrap;

    pre_d     = pre_q + PRESCALE_BITS'(1);
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    cup_d     = cup_q;
    irqen_d   = irqen_q;
    en_d      = en_q;
    overflow  = '0;
    irq_pulse = '0;
    carry     = 1'b0;

    // Timers are evaluated in ascending order so a wrap chain can ripple
    // through the whole bank in a single cycle.
    for (int n = 0; n < NUM_TIMERS; n++) begin
      case (presc_q[n])
        2'b00:   sel_tick = 1'b1;
        2'b01:   sel_tick = tick_64;
        2'b10:   sel_tick = tick_256;
        default: sel_tick = tick_1024;
      endcase

      inc      = (cup_q[n] && n > 0) ? carry : sel_tick;
      ctrl_wr  = wr_en & wr_ctrl & (wr_idx == IDX_W'(n));
      rel_wr   = wr_en & ~wr_ctrl & (wr_idx == IDX_W'(n));
      stopping = ctrl_wr & ~wr_data[7];
      starting = ctrl_wr & wr_data[7] & ~en_q[n];
      wrap     = 1'b0;

      if (ctrl_wr) begin
        presc_d[n] = wr_data[1:0];
        cup_d[n]   = wr_data[2];
        irqen_d[n] = wr_data[6];
        en_d[n]    = wr_data[7];
      end

      // A wrap in the same cycle still reads reload_q, i.e. the old value.
      if (rel_wr) begin
        reload_d[n] = wr_data;
      end

      if (starting) begin
        cnt_d[n] = reload_q[n];
      end else if (en_q[n] && !stopping && inc) begin
        if (&cnt_q[n]) begin
          cnt_d[n] = reload_q[n];
          wrap     = 1'b1;
        end else begin
          cnt_d[n] = cnt_q[n] + WIDTH'(1);
        end
      end

      overflow[n]  = wrap;
      irq_pulse[n] = wrap & irqen_q[n];
      carry        = wrap;
    end
  end

  always_ff @(posedge internal_clock or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      cup_q   <= '0;
      irqen_q <= '0;
      en_q    <= '0;
      for (int n = 0; n < NUM_TIMERS; n++) begin
        cnt_q[n]    <= '0;
        reload_q[n] <= '0;
        presc_q[n]  <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      cup_q    <= cup_d;
      irqen_q  <= irqen_d;
      en_q     <= en_d;
    end
  end

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_count_out
    assign count_out[n*WIDTH +: WIDTH] = cnt_q[n];
  end

`ifdef TIMER_IRQ_LATCH_EN
  logic [NUM_TIMERS-1:0] irq_q, irq_d;

  // A new overflow takes priority over an acknowledge in the same cycle.
  always_comb begin
    irq_d = irq_pulse | (irq_q & ~irq_ack);
  end

  always_ff @(posedge internal_clock or posedge reset) begin
    if (reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = ^irq_ack;
  assign irq            = irq_pulse;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gba_timer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gba_timer_bank                                          |
// | Description : Directed, table-driven bench for gba_timer_bank (4 x 16b). |
// |               Inputs are driven on the falling edge. Outputs are sampled |
// |               1 time unit later, which is the state before the next      |
// |               rising edge.                                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gba_timer_bank;

  logic        internal_clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic        wr_ctrl;
  logic [15:0] wr_data;
  logic [3:0]  irq_ack;
  logic [63:0] count_out;
  logic [3:0]  overflow;
  logic [3:0]  irq;

  int checks = 0;
  int errors = 0;
  int pre_m  = 0;   // prescaler model: rising edges since reset release

  gba_timer_bank #(
    .NUM_TIMERS    (4),
    .WIDTH         (16),
    .PRESCALE_BITS (10)
  ) dut (
    .internal_clock (internal_clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_ctrl        (wr_ctrl),
    .wr_data        (wr_data),
    .irq_ack        (irq_ack),
    .count_out      (count_out),
    .overflow       (overflow),
    .irq            (irq)
  );

  always #5 internal_clock = ~internal_clock;

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic        ctl;
    logic [15:0] data;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [3:0]  ov;
    logic [3:0]  irq;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input logic we, input logic [1:0] idx, input logic ctl,
                              input logic [15:0] data, input logic [15:0] c0,
                              input logic [15:0] c1, input logic [3:0] ov,
                              input logic [3:0] iq);
    vec_t v;
    v.we = we; v.idx = idx; v.ctl = ctl; v.data = data;
    v.c0 = c0; v.c1 = c1; v.ov = ov; v.irq = iq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] idx, input logic ctl,
                       input logic [15:0] d, input logic [3:0] ack);
    wr_en   = we;
    wr_idx  = idx;
    wr_ctrl = ctl;
    wr_data = d;
    irq_ack = ack;
    #1;
  endtask

  task automatic advance();
    @(posedge internal_clock);
    if (!reset) pre_m++;
    @(negedge internal_clock);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'h0);
  endtask

  initial begin
    // Test 1: /1 wrap at 0xFFFD reload; test 5: disable at 0x0005;
    // test 3: cascade of timer1 on timer0 wraps.
    tbl[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0);
    tbl[1]  = mk(1, 0, 0, 16'hFFFD, 16'h0000, 16'h0000, 4'h0, 4'h0);
    tbl[2]  = mk(1, 0, 1, 16'h0080, 16'h0000, 16'h0000, 4'h0, 4'h0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 16'hFFFD, 16'h0000, 4'h0, 4'h0);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 4'h1, 4'h0);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 16'hFFFD, 16'h0000, 4'h0, 4'h0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 4'h1, 4'h0);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 16'hFFFD, 16'h0000, 4'h0, 4'h0);
    tbl[10] = mk(1, 0, 1, 16'h0000, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[11] = mk(0, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[12] = mk(1, 0, 0, 16'h0003, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[13] = mk(1, 0, 1, 16'h0080, 16'hFFFE, 16'h0000, 4'h0, 4'h0);
    tbl[14] = mk(0, 0, 0, 16'h0000, 16'h0003, 16'h0000, 4'h0, 4'h0);
    tbl[15] = mk(0, 0, 0, 16'h0000, 16'h0004, 16'h0000, 4'h0, 4'h0);
    tbl[16] = mk(1, 0, 1, 16'h0000, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[17] = mk(0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[18] = mk(0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[19] = mk(1, 0, 0, 16'hFFFF, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[20] = mk(1, 1, 0, 16'hFFFE, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[21] = mk(1, 1, 1, 16'h00C4, 16'h0005, 16'h0000, 4'h0, 4'h0);
    tbl[22] = mk(1, 0, 1, 16'h0080, 16'h0005, 16'hFFFE, 4'h0, 4'h0);
    tbl[23] = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFE, 4'h1, 4'h0);
    tbl[24] = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h3, 4'h2);
    tbl[25] = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFE, 4'h1, 4'h0);
    tbl[26] = mk(1, 0, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h0, 4'h0);
    tbl[27] = mk(1, 1, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h0, 4'h0);
    tbl[28] = mk(0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h0, 4'h0);

    reset = 1'b1;
    wr_en = 1'b0; wr_idx = 2'd0; wr_ctrl = 1'b0; wr_data = 16'h0; irq_ack = 4'h0;
    repeat (2) @(negedge internal_clock);
    #1;
    chk("reset_count", count_out, 64'h0);
    chk("reset_ovf", {60'h0, overflow}, 64'h0);
    chk("reset_irq", {60'h0, irq}, 64'h0);
    @(negedge internal_clock);
    reset = 1'b0;
    pre_m = 0;

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].we, tbl[i].idx, tbl[i].ctl, tbl[i].data, 4'h0);
      chk($sformatf("vec%0d_cnt0", i), {48'h0, count_out[15:0]}, {48'h0, tbl[i].c0});
      chk($sformatf("vec%0d_cnt1", i), {48'h0, count_out[31:16]}, {48'h0, tbl[i].c1});
      chk($sformatf("vec%0d_ovf", i), {60'h0, overflow}, {60'h0, tbl[i].ov});
`ifndef TIMER_IRQ_LATCH_EN
      chk($sformatf("vec%0d_irq", i), {60'h0, irq}, {60'h0, tbl[i].irq});
`endif
      advance();
    end

    // Test 4: reload written in the exact wrap cycle; the wrap uses the old value.
    drive(1, 0, 0, 16'hFFF0, 4'h0); advance();
    drive(1, 0, 1, 16'h0080, 4'h0);
    chk("t4_start_ovf", {60'h0, overflow}, 64'h0);
    advance();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        if (pass == 0 && i == 15) drive(1, 0, 0, 16'h1234, 4'h0);
        else idle();
        chk($sformatf("t4_p%0d_cnt%0d", pass, i), {48'h0, count_out[15:0]}, 64'(16'hFFF0 + i));
        chk($sformatf("t4_p%0d_ovf%0d", pass, i), {60'h0, overflow}, (i == 15) ? 64'h1 : 64'h0);
        advance();
      end
    end
    idle();
    chk("t4_new_reload", {48'h0, count_out[15:0]}, 64'h1234);
    advance();
    drive(1, 0, 1, 16'h0000, 4'h0); advance();

    // Test 2: /64 with irq_en, reload 0xFFFF: a wrap each time pre[5:0] == 63.
    drive(1, 0, 0, 16'hFFFF, 4'h0); advance();
    drive(1, 0, 1, 16'h00C1, 4'h0); advance();
    for (int i = 0; i < 200; i++) begin
      idle();
      chk($sformatf("t2_cnt%0d", i), {48'h0, count_out[15:0]}, 64'hFFFF);
      chk($sformatf("t2_ovf%0d", i), {60'h0, overflow}, ((pre_m % 64) == 63) ? 64'h1 : 64'h0);
`ifndef TIMER_IRQ_LATCH_EN
      chk($sformatf("t2_irq%0d", i), {60'h0, irq}, ((pre_m % 64) == 63) ? 64'h1 : 64'h0);
`endif
      advance();
    end

    // Test 6: asynchronous reset in the middle of a running, wrapping timer.
    drive(1, 0, 1, 16'h0080, 4'h0); advance();
    idle();
    chk("t6_pre_ovf", {60'h0, overflow}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_count", count_out, 64'h0);
    chk("t6_async_ovf", {60'h0, overflow}, 64'h0);
    chk("t6_async_irq", {60'h0, irq}, 64'h0);
    @(negedge internal_clock);
    reset = 1'b0;
    pre_m = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("t6_stopped_cnt%0d", i), count_out, 64'h0);
      chk($sformatf("t6_stopped_ovf%0d", i), {60'h0, overflow}, 64'h0);
      advance();
    end

`ifdef TIMER_IRQ_LATCH_EN
    // Sticky IRQ: set the cycle after the wrap, set beats ack, clear after ack.
    drive(1, 0, 0, 16'hFFFF, 4'h0); advance();
    drive(1, 0, 1, 16'h00C0, 4'h0);
    chk("lat_irq_idle", {60'h0, irq}, 64'h0);
    advance();
    idle();
    chk("lat_first_ovf", {60'h0, overflow}, 64'h1);
    chk("lat_not_yet", {60'h0, irq}, 64'h0);
    advance();
    drive(0, 0, 0, 16'h0000, 4'h1);
    chk("lat_set", {60'h0, irq}, 64'h1);
    advance();
    drive(1, 0, 1, 16'h0000, 4'h0);
    chk("lat_set_beats_ack", {60'h0, irq}, 64'h1);
    chk("lat_stop_ovf", {60'h0, overflow}, 64'h0);
    advance();
    idle();
    chk("lat_hold", {60'h0, irq}, 64'h1);
    advance();
    drive(0, 0, 0, 16'h0000, 4'h1);
    chk("lat_ack_cycle", {60'h0, irq}, 64'h1);
    advance();
    idle();
    chk("lat_cleared", {60'h0, irq}, 64'h0);
    advance();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gba_timer_bank.md
Name: gba_timer_bank

Overview:
- Parametrised bank of NUM_TIMERS GBA-style up-counters with a shared prescaler, a reload register per timer, cascade (count-up) chaining, and overflow interrupts.
- Supersedes the single-channel timer.
- Overflow pulses of timers 0/1 clock the direct-sound FIFOs.
- IRQ lines go to the interrupt controller.
- Register writes arrive on a simple write port; the live counter values are always readable.

Parameters:
- NUM_TIMERS, 4: number of timer channels (1..8).
- WIDTH, 16: counter/reload width in bits (>= 8).
- PRESCALE_BITS, 10: width of the shared prescaler counter; sets the divide-by-1024 maximum.

Ports:
- internal_clock, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write strobe, one write per cycle.
- wr_idx, input, $clog2(NUM_TIMERS) (min 1): target timer.
- wr_ctrl, input, 1: 1 = write control register, 0 = write reload register.
- wr_data, input, WIDTH: write data; control uses bits [7:0].
- irq_ack, input, NUM_TIMERS: per-timer IRQ acknowledge (used only with TIMER_IRQ_LATCH_EN).
- count_out, output, NUM_TIMERS*WIDTH: live counters, timer n at [n*WIDTH +: WIDTH].
- overflow, output, NUM_TIMERS: 1-cycle pulse when timer n wraps.
- irq, output, NUM_TIMERS: interrupt request per timer.

Behaviour:
- Control register fields:
  - [1:0] prescale: 00 = /1, 01 = /64, 10 = /256, 11 = /1024.
  - [2] count_up: cascade mode.
  - [6] irq_en.
  - [7] enable.
  - All other bits are ignored and read as zero internally.
- Reset values: all counters, reload registers, control registers, the prescaler, overflow and irq are 0.
- Prescaler:
  - Free-running PRESCALE_BITS counter, incrementing every cycle regardless of timer state.
  - Tick for /64 is asserted when pre[5:0] == 63; /256 when pre[7:0] == 255; /1024 when pre[9:0] == 1023; /1 ticks every cycle.
- Increment source for timer n:
  - count_up = 1 and n > 0: increments only when overflow of timer n-1 is asserted in the same cycle. The prescale field is ignored.
  - Otherwise: increments on the selected prescaler tick.
  - count_up on timer 0 is ignored.
- Cascade propagation: combinational ripple. A chain of overflows across all timers resolves in one cycle.
- Start: a control write taking enable from 0 to 1 loads the counter with the reload value at that edge. The first increment happens on the first qualifying tick after that edge, never the same cycle.
- Running (enable = 1): on each increment event, if counter == all-ones:
  - counter <= reload;
  - overflow[n] = 1 for that cycle;
  - irq per irq_en.
  - Otherwise counter <= counter + 1.
- Stopped (enable = 0): counter holds its value. No overflow, no irq.
- Writing reload while running only changes the value loaded on the next start or wrap. It never modifies the live counter.
- Simultaneous events in one cycle:
  - Reload write + wrap: the wrap loads the OLD reload; the new value takes effect afterwards.
  - Control write clearing enable + tick: disable wins; no increment, no overflow.
  - Control write setting enable (0->1) + tick: load reload only.
  - Control write while running with enable kept at 1: fields update; the counter is not reloaded.
- irq (default, macro off): irq[n] = overflow[n] & irq_en[n]. It is a 1-cycle pulse, combinational from the overflow condition.
- Reset asserted mid-count: everything clears immediately, asynchronously. After release, the timers stay stopped until their control registers are written.

Optional Feature:
- Macro: TIMER_IRQ_LATCH_EN.
- Defined:
  - irq[n] is a registered sticky flag, set on the cycle after overflow[n] & irq_en[n].
  - The flag clears on the cycle after irq_ack[n] = 1.
  - Simultaneous set and ack: set wins.
  - Reset clears all flags.
- Undefined: irq is the pulse described above, and irq_ack is ignored.

Test Plan:
1. Reset, reload0 = 0xFFFD, ctrl0 = 0x80 (/1, enable):
   - count_out[0] goes 0xFFFD, 0xFFFE, 0xFFFF, then back to 0xFFFD;
   - overflow[0] pulses for exactly 1 cycle on the wrap;
   - irq[0] stays 0.
2. ctrl0 = 0xC1 (/64, irq_en), reload 0xFFFF:
   - exactly one increment per 64 cycles, aligned to pre[5:0] == 63;
   - overflow[0] and irq[0] pulse every 64 cycles.
3. Cascade: timer0 0xFFFF/ctrl 0x80, timer1 reload 0xFFFE/ctrl 0xC4:
   - timer1 increments on each timer0 wrap;
   - on its second increment timer1 wraps in the same cycle as timer0, and overflow[1], irq[1] and overflow[0] are all 1 together.
4. Write reload0 = 0x1234 in the exact cycle timer0 wraps (old reload 0xFFF0):
   - counter loads 0xFFF0;
   - the next wrap loads 0x1234.
5. Write ctrl0 = 0x00 during a /1 tick at count 0x0005: counter holds 0x0005, no overflow.
6. Reset pulse mid-count: all count_out, overflow and irq are 0 immediately. With TIMER_IRQ_LATCH_EN also check:
   - irq[0] sets the cycle after the wrap and holds;
   - it clears 1 cycle after irq_ack[0];
   - set + ack in the same cycle leaves irq[0] = 1.
